ats_eligibility_arbiter: RTL and testbench

//  Two-input frame scheduler for the ATS egress path, downstream of two deadline-filtered streams (frame + timestamp sidecar).

---
 rtl/ats_eligibility_arbiter.sv | 103 ++++++++++
 tb/tb_ats_eligibility_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ats_eligibility_arbiter.sv
`timescale 1ns/1ps
// ats_eligibility_arbiter: two-input ATS frame scheduler, earliest eligible timestamp wins, frame-atomic registered output; ATS_ELIG_ARB_STATS_EN adds per-input frame counters
module ats_eligibility_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH/8,
    parameter int TIMESTAMP_WIDTH    = 72
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TIMESTAMP_WIDTH-1:0]    current_time,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                          s0_axis_tvalid,
    output logic                          s0_axis_tready,
    input  logic                          s0_axis_tlast,
    input  logic [TIMESTAMP_WIDTH-1:0]    s0_axis_timestamp_tdata,
    input  logic                          s0_axis_timestamp_tvalid,
    output logic                          s0_axis_timestamp_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                          s1_axis_tvalid,
    output logic                          s1_axis_tready,
    input  logic                          s1_axis_tlast,
    input  logic [TIMESTAMP_WIDTH-1:0]    s1_axis_timestamp_tdata,
    input  logic                          s1_axis_timestamp_tvalid,
    output logic                          s1_axis_timestamp_tready,
`ifdef ATS_ELIG_ARB_STATS_EN
    output logic [31:0]                   stat_frames0,
    output logic [31:0]                   stat_frames1,
`endif
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser
);
    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;
    state_t state;
    logic last_grant;
    logic elig0, elig1, pick, grant, out_free, beat0, beat1, beat, in_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] in_data;
    logic [C_AXIS_TKEEP_WIDTH-1:0] in_keep;
    always_comb begin
        elig0 = s0_axis_timestamp_tvalid && (s0_axis_timestamp_tdata <= current_time);
        elig1 = s1_axis_timestamp_tvalid && (s1_axis_timestamp_tdata <= current_time);
        // equal timestamps fall back to round-robin against the previous grant
        pick = (elig0 && elig1) ? ((s0_axis_timestamp_tdata == s1_axis_timestamp_tdata) ? !last_grant
                                   : (s1_axis_timestamp_tdata < s0_axis_timestamp_tdata)) : elig1;
        grant = !rst && (state == IDLE) && (elig0 || elig1);
        s0_axis_timestamp_tready = grant && !pick;
        s1_axis_timestamp_tready = grant && pick;
        out_free = !m_axis_tvalid || m_axis_tready;
        s0_axis_tready = !rst && (state == SEND0) && out_free;
        s1_axis_tready = !rst && (state == SEND1) && out_free;
        beat0 = s0_axis_tvalid && s0_axis_tready;
        beat1 = s1_axis_tvalid && s1_axis_tready;
        beat = beat0 || beat1;
        in_data = (state == SEND1) ? s1_axis_tdata : s0_axis_tdata;
        in_keep = (state == SEND1) ? s1_axis_tkeep : s0_axis_tkeep;
        in_last = (state == SEND1) ? s1_axis_tlast : s0_axis_tlast;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= 1'b1;
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else begin
            if (beat) begin
                m_axis_tdata <= in_data;
                m_axis_tkeep <= in_keep;
                m_axis_tlast <= in_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state)
                IDLE: if (grant) begin
                    last_grant <= pick;
                    m_axis_tuser <= pick;
                    state <= pick ? SEND1 : SEND0;
                end
                SEND0, SEND1: if (beat && in_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ATS_ELIG_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames0 <= '0;
            stat_frames1 <= '0;
        end else begin
            if (beat0 && s0_axis_tlast && stat_frames0 != '1) stat_frames0 <= stat_frames0 + 32'd1;
            if (beat1 && s1_axis_tlast && stat_frames1 != '1) stat_frames1 <= stat_frames1 + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ats_eligibility_arbiter.sv
`timescale 1ns/1ps
// tb_ats_eligibility_arbiter: directed vectors for the ATS eligibility arbiter
module tb_ats_eligibility_arbiter;
    localparam int TW = 72;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    int cyc_start = 0;
    logic ct_run = 1'b0;
    logic [TW-1:0] ct_base = '0;
    logic [TW-1:0] ct;
    assign ct = ct_run ? ct_base + TW'(cyc - cyc_start) : ct_base;
    always @(posedge clk) cyc <= cyc + 1;
    logic [7:0] s_data [2];
    logic s_valid [2];
    logic s_ready [2];
    logic s_last [2];
    logic [TW-1:0] ts_data [2];
    logic ts_valid [2];
    logic ts_ready [2];
    logic [7:0] m_data;
    logic [0:0] m_keep;
    logic m_valid, m_last, m_user;
    logic m_rdy = 1'b1;
`ifdef ATS_ELIG_ARB_STATS_EN
    logic [31:0] stat0, stat1;
`endif
    ats_eligibility_arbiter dut (
        .clk(clk), .rst(rst), .current_time(ct),
        .s0_axis_tdata(s_data[0]), .s0_axis_tkeep(1'b1), .s0_axis_tvalid(s_valid[0]),
        .s0_axis_tready(s_ready[0]), .s0_axis_tlast(s_last[0]),
        .s0_axis_timestamp_tdata(ts_data[0]), .s0_axis_timestamp_tvalid(ts_valid[0]),
        .s0_axis_timestamp_tready(ts_ready[0]),
        .s1_axis_tdata(s_data[1]), .s1_axis_tkeep(1'b1), .s1_axis_tvalid(s_valid[1]),
        .s1_axis_tready(s_ready[1]), .s1_axis_tlast(s_last[1]),
        .s1_axis_timestamp_tdata(ts_data[1]), .s1_axis_timestamp_tvalid(ts_valid[1]),
        .s1_axis_timestamp_tready(ts_ready[1]),
`ifdef ATS_ELIG_ARB_STATS_EN
        .stat_frames0(stat0), .stat_frames1(stat1),
`endif
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tlast(m_last), .m_axis_tready(m_rdy), .m_axis_tuser(m_user)
    );
    int q_data[$], q_user[$], q_last[$], q_cyc[$];
    int e_data[$], e_user[$], e_last[$];
    always @(negedge clk) begin
        if (!rst && m_valid && m_rdy) begin
            q_data.push_back(int'(m_data));
            q_user.push_back(int'(m_user));
            q_last.push_back(int'(m_last));
            q_cyc.push_back(cyc);
        end
    end
    int checks = 0;
    int failures = 0;
    logic [TW-1:0] grant_ct [2];
    logic tog_done;
    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic expect_frame(input int u, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            e_data.push_back((base + k) & 8'hff);
            e_user.push_back(u);
            e_last.push_back(int'(k == n - 1));
        end
    endtask
    task automatic wait_beats(input int n);
        int c = 0;
        while (q_data.size() < n && c < 300) begin
            @(posedge clk);
            c++;
        end
        #1;
    endtask
    task automatic compare(input string tag);
        check({tag, "_count"}, TW'(q_data.size()), TW'(e_data.size()));
        for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), TW'(q_data[i]), TW'(e_data[i]));
            check($sformatf("%s_user%0d", tag, i), TW'(q_user[i]), TW'(e_user[i]));
            check($sformatf("%s_last%0d", tag, i), TW'(q_last[i]), TW'(e_last[i]));
        end
        q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
        e_data.delete(); e_user.delete(); e_last.delete();
    endtask
    task automatic send_frame(input int i, input logic [TW-1:0] ts, input int base, input int n, input int delay);
        int k = 0;
        int c = 0;
        int early = 0;
        logic hs_t, hs_d;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        ts_data[i] = ts;
        ts_valid[i] = 1'b1;
        s_data[i] = 8'(base);
        s_last[i] = (n == 1);
        s_valid[i] = 1'b1;
        while ((ts_valid[i] || k < n) && c < 2000) begin
            @(negedge clk);
            hs_t = ts_valid[i] && ts_ready[i];
            hs_d = s_valid[i] && s_ready[i];
            if (hs_t) grant_ct[i] = ct;
            if (hs_d && ts_valid[i]) early++;
            @(posedge clk);
            #1;
            if (hs_t) ts_valid[i] = 1'b0;
            if (hs_d) begin
                k++;
                s_valid[i] = (k < n);
                s_data[i] = 8'(base + k);
                s_last[i] = (k == n - 1);
            end
            c++;
        end
        check($sformatf("timeout_s%0d", i), TW'(c >= 2000), '0);
        check($sformatf("early_beat_s%0d", i), TW'(early), '0);
        ts_valid[i] = 1'b0;
        s_valid[i] = 1'b0;
    endtask
    initial begin
        int c, tl;
        logic hs, hd;
        for (int i = 0; i < 2; i++) begin
            s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0;
            ts_data[i] = '0; ts_valid[i] = 1'b0; grant_ct[i] = '0;
        end
        ts_valid[0] = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", TW'(m_valid), '0);
        check("rst_tuser", TW'(m_user), '0);
        check("rst_tlast", TW'(m_last), '0);
        check("rst_tdata", TW'(m_data), '0);
        check("rst_s0_tready", TW'(s_ready[0]), '0);
        check("rst_s1_tready", TW'(s_ready[1]), '0);
        check("rst_ts0_tready", TW'(ts_ready[0]), '0);
        ts_valid[0] = 1'b0;
        rst = 1'b0;
        // waits until current_time reaches 100
        ct_base = 50; cyc_start = cyc; ct_run = 1'b1;
        expect_frame(0, 'h10, 4);
        send_frame(0, 100, 'h10, 4, 0);
        wait_beats(4);
        check("t1_grant_time", grant_ct[0], 100);
        check("t1_keep", TW'(m_keep), 1);
        compare("t1");
        ct_run = 1'b0;
        // earlier timestamp wins, loser follows right after tlast
        ct_base = 40;
        expect_frame(1, 'h20, 3);
        expect_frame(0, 'h50, 3);
        fork
            send_frame(0, 30, 'h50, 3, 0);
            send_frame(1, 20, 'h20, 3, 0);
        join
        wait_beats(6);
        if (q_cyc.size() >= 4) check("t2_gap", TW'(q_cyc[3] - q_cyc[2]), 2);
        compare("t2");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // equal timestamps alternate starting from s0 after reset
        ct_base = 20;
        expect_frame(0, 'h30, 2);
        expect_frame(1, 'h40, 2);
        expect_frame(0, 'h60, 2);
        expect_frame(1, 'h70, 2);
        fork
            send_frame(0, 10, 'h30, 2, 0);
            send_frame(1, 10, 'h40, 2, 0);
        join
        fork
            send_frame(0, 10, 'h60, 2, 0);
            send_frame(1, 10, 'h70, 2, 0);
        join
        wait_beats(8);
        compare("t3");
        // output back-pressure toggling every cycle
        expect_frame(0, 'h80, 8);
        tog_done = 1'b0;
        fork
            begin
                send_frame(0, 5, 'h80, 8, 0);
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1;
                    m_rdy = ~m_rdy;
                end
                m_rdy = 1'b1;
            end
        join
        wait_beats(8);
        compare("t4");
        // earlier s1 arrives mid s0 frame, no preemption
        expect_frame(0, 'h90, 6);
        expect_frame(1, 'ha0, 2);
        fork
            send_frame(0, 5, 'h90, 6, 0);
            send_frame(1, 3, 'ha0, 2, 3);
        join
        wait_beats(8);
        if (q_cyc.size() >= 7) check("t5_gap", TW'(q_cyc[6] - q_cyc[5]), 2);
        compare("t5");
`ifdef ATS_ELIG_ARB_STATS_EN
        check("stat0", TW'(stat0), 4);
        check("stat1", TW'(stat1), 3);
`endif
        // reset in the middle of a 6-beat frame
        ts_data[0] = '0; ts_valid[0] = 1'b1;
        s_data[0] = 8'hc0; s_last[0] = 1'b0; s_valid[0] = 1'b1;
        c = 0;
        while (q_data.size() < 3 && c < 100) begin
            @(negedge clk);
            hs = ts_valid[0] && ts_ready[0];
            hd = s_valid[0] && s_ready[0];
            @(posedge clk);
            #1;
            if (hs) ts_valid[0] = 1'b0;
            if (hd) s_data[0] = s_data[0] + 8'd1;
            c++;
        end
        check("t6_reach_beat3", TW'(q_data.size() >= 3), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_tvalid_drop", TW'(m_valid), '0);
        check("t6_s0_tready", TW'(s_ready[0]), '0);
        s_valid[0] = 1'b0;
        ts_valid[0] = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_tvalid_idle", TW'(m_valid), '0);
        tl = 0;
        foreach (q_last[i]) tl += q_last[i];
        check("t6_no_tlast", TW'(tl), '0);
`ifdef ATS_ELIG_ARB_STATS_EN
        check("t6_stat0", TW'(stat0), '0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
